// File: rtl/ascon_byte_packer.sv
// Packs a valid/ready byte stream (AD or message) into 64-bit zero-filled blocks
// for the ASCON core, with one assembly register and one output register.
module ascon_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic        in_nob,
   input  logic        in_ad,
   output logic        in_ready,
   output logic [63:0] blk_data,
   output logic [3:0]  blk_len,
   output logic        blk_last,
   output logic        blk_ad,
   output logic        blk_valid,
   input  logic        blk_read
);

   logic [63:0] asm_data_q, asm_data_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        asm_ad_q, asm_ad_d;
   logic        done_q, done_d;
   logic [3:0]  hold_len_q, hold_len_d;
   logic        hold_last_q, hold_last_d;
   logic [63:0] blk_data_q, blk_data_d;
   logic [3:0]  blk_len_q, blk_len_d;
   logic        blk_last_q, blk_last_d;
   logic        blk_ad_q, blk_ad_d;
   logic        blk_valid_q, blk_valid_d;

   logic        accept;
   logic        out_free;
   logic        complete;
   logic        beat_ad;
   logic        beat_last;
   logic [3:0]  comp_len;
   logic [63:0] merged;

   always_comb begin
      accept    = in_valid & ~done_q;
      out_free  = ~blk_valid_q | blk_read;
      beat_ad   = (cnt_q == 3'd0) ? in_ad : asm_ad_q;
      // A lone no-byte beat is treated as closing the segment.
      beat_last = in_last | in_nob;
      complete  = accept & (beat_last | (cnt_q == 3'd7));
      comp_len  = in_nob ? {1'b0, cnt_q} : ({1'b0, cnt_q} + 4'd1);
      merged    = asm_data_q;
      for (int i = 0; i < 8; i++) begin
         if (!in_nob && (cnt_q == i[2:0])) begin
            merged[63-8*i -: 8] = in_data;
         end
      end

      asm_data_d  = asm_data_q;
      cnt_d       = cnt_q;
      asm_ad_d    = asm_ad_q;
      done_d      = done_q;
      hold_len_d  = hold_len_q;
      hold_last_d = hold_last_q;
      blk_data_d  = blk_data_q;
      blk_len_d   = blk_len_q;
      blk_last_d  = blk_last_q;
      blk_ad_d    = blk_ad_q;
      blk_valid_d = blk_valid_q;

      if (done_q) begin
         // Held block moves out on the read edge; the output never empties here.
         if (blk_read) begin
            blk_data_d  = asm_data_q;
            blk_len_d   = hold_len_q;
            blk_last_d  = hold_last_q;
            blk_ad_d    = asm_ad_q;
            blk_valid_d = 1'b1;
            done_d      = 1'b0;
            asm_data_d  = 64'd0;
            cnt_d       = 3'd0;
            asm_ad_d    = 1'b0;
         end
      end else if (complete) begin
         if (out_free) begin
            blk_data_d  = merged;
            blk_len_d   = comp_len;
            blk_last_d  = beat_last;
            blk_ad_d    = beat_ad;
            blk_valid_d = 1'b1;
            asm_data_d  = 64'd0;
            cnt_d       = 3'd0;
            asm_ad_d    = 1'b0;
         end else begin
            asm_data_d  = merged;
            hold_len_d  = comp_len;
            hold_last_d = beat_last;
            asm_ad_d    = beat_ad;
            cnt_d       = 3'd0;
            done_d      = 1'b1;
         end
      end else begin
         if (accept) begin
            asm_data_d = merged;
            cnt_d      = cnt_q + 3'd1;
            asm_ad_d   = beat_ad;
         end
         if (blk_read && blk_valid_q) begin
            blk_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_data_q  <= 64'd0;
         cnt_q       <= 3'd0;
         asm_ad_q    <= 1'b0;
         done_q      <= 1'b0;
         hold_len_q  <= 4'd0;
         hold_last_q <= 1'b0;
         blk_data_q  <= 64'd0;
         blk_len_q   <= 4'd0;
         blk_last_q  <= 1'b0;
         blk_ad_q    <= 1'b0;
         blk_valid_q <= 1'b0;
      end else begin
         asm_data_q  <= asm_data_d;
         cnt_q       <= cnt_d;
         asm_ad_q    <= asm_ad_d;
         done_q      <= done_d;
         hold_len_q  <= hold_len_d;
         hold_last_q <= hold_last_d;
         blk_data_q  <= blk_data_d;
         blk_len_q   <= blk_len_d;
         blk_last_q  <= blk_last_d;
         blk_ad_q    <= blk_ad_d;
         blk_valid_q <= blk_valid_d;
      end
   end

   assign in_ready  = ~done_q;
   assign blk_data  = blk_data_q;
   assign blk_len   = blk_len_q;
   assign blk_last  = blk_last_q;
   assign blk_ad    = blk_ad_q;
   assign blk_valid = blk_valid_q;

endmodule

// File: tb/tb_ascon_byte_packer.sv
// Directed bench for ascon_byte_packer: driver tasks push expected blocks,
// a negedge monitor pops and compares each block as the core reads it.
module tb_ascon_byte_packer;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_nob;
   logic        in_ad;
   logic        in_ready;
   logic [63:0] blk_data;
   logic [3:0]  blk_len;
   logic        blk_last;
   logic        blk_ad;
   logic        blk_valid;
   logic        blk_read;

   int total = 0;
   int bad   = 0;
   // Expected block = {data[63:0], len[3:0], last, ad}
   logic [69:0] exp_q[$];

   ascon_byte_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_nob    (in_nob),
      .in_ad     (in_ad),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_len   (blk_len),
      .blk_last  (blk_last),
      .blk_ad    (blk_ad),
      .blk_valid (blk_valid),
      .blk_read  (blk_read)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a block is consumed on an edge where blk_read and blk_valid are both high.
   always @(negedge clk) begin
      if (!rst && blk_valid && blk_read) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got %h %0d %b %b expected none", blk_data, blk_len, blk_last, blk_ad);
         end else begin
            check("block", {blk_data, blk_len, blk_last, blk_ad}, exp_q.pop_front());
         end
      end
   end

   // Drive one beat starting just after a posedge; returns just after the accepting edge.
   task automatic send_beat(input logic [7:0] d, input logic last, input logic nob, input logic ad);
      int   guard;
      logic rdy;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_nob   = nob;
      in_ad    = ad;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         guard++;
         if (guard > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_nob   = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic pulse_read();
      blk_read = 1'b1;
      @(posedge clk);
      #1;
      blk_read = 1'b0;
   endtask

   // Send n consecutive bytes from first, pushing the expected blocks as they are issued.
   task automatic send_seq(input logic [7:0] first, input int n, input logic ad, input logic last);
      logic [63:0] d;
      logic [7:0]  b;
      logic        is_last;
      int          k;
      d = 64'd0;
      k = 0;
      for (int i = 0; i < n; i++) begin
         b = first + 8'(i);
         d[63-8*k -: 8] = b;
         k++;
         is_last = last && (i == n - 1);
         if (k == 8 || is_last) begin
            exp_q.push_back({d, 4'(k), is_last, ad});
            d = 64'd0;
            k = 0;
         end
         send_beat(b, is_last, 1'b0, ad);
      end
   endtask

   initial begin
      rst      = 1'b1;
      blk_read = 1'b0;
      in_ad    = 1'b0;
      idle();
      @(negedge clk);
      check("reset_in_ready", {69'd0, in_ready}, {69'd0, 1'b1});
      check("reset_outputs", {blk_data, blk_len, blk_last, blk_ad}, 70'd0);
      check("reset_valid", {69'd0, blk_valid}, 70'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic 8-byte AD block, read held low.
      send_seq(8'h01, 7, 1'b1, 1'b0);
      check("basic_not_yet_valid", {69'd0, blk_valid}, 70'd0);
      send_seq(8'h08, 1, 1'b1, 1'b1);
      idle();
      check("basic_valid", {69'd0, blk_valid}, {69'd0, 1'b1});
      exp_q.pop_back();
      // Block fields checked directly here; re-queue it for the monitor.
      check("basic_fields", {blk_data, blk_len, blk_last, blk_ad},
            {64'h0102030405060708, 4'd8, 1'b1, 1'b1});
      exp_q.push_back({64'h0102030405060708, 4'd8, 1'b1, 1'b1});
      repeat (2) @(posedge clk);
      #1;
      check("basic_hold", {69'd0, blk_valid}, {69'd0, 1'b1});
      pulse_read();
      check("basic_release", {69'd0, blk_valid}, 70'd0);
      check("basic_data_held", {6'd0, blk_data}, {6'd0, 64'h0102030405060708});

      // Multi-block PT segment with a short tail.
      exp_q.push_back({64'hA0A1A2A3A4A5A6A7, 4'd8, 1'b0, 1'b0});
      exp_q.push_back({64'hA8A9AA0000000000, 4'd3, 1'b1, 1'b0});
      for (int i = 0; i < 11; i++) send_beat(8'hA0 + 8'(i), (i == 10), 1'b0, 1'b0);
      idle();
      check("multi_ready_low", {69'd0, in_ready}, 70'd0);
      pulse_read();
      check("multi_ready_high", {69'd0, in_ready}, {69'd0, 1'b1});
      check("multi_still_valid", {69'd0, blk_valid}, {69'd0, 1'b1});
      pulse_read();

      // Empty segment: single no-byte last beat.
      exp_q.push_back({64'd0, 4'd0, 1'b1, 1'b0});
      send_beat(8'hFF, 1'b1, 1'b1, 1'b0);
      idle();
      pulse_read();

      // Short AD segment, then aligned segment closed by an explicit pad beat.
      send_seq(8'hC1, 3, 1'b1, 1'b1);
      idle();
      pulse_read();
      send_seq(8'h30, 8, 1'b0, 1'b0);
      exp_q.push_back({64'd0, 4'd0, 1'b1, 1'b0});
      send_beat(8'h00, 1'b1, 1'b1, 1'b0);
      idle();
      pulse_read();
      pulse_read();

      // Back-pressure: 24 bytes, read only every 20 cycles.
      fork
         begin
            send_seq(8'h40, 24, 1'b0, 1'b1);
            idle();
         end
         begin
            repeat (3) begin
               repeat (20) @(posedge clk);
               #1;
               pulse_read();
            end
         end
         begin
            repeat (18) @(negedge clk);
            check("bp_ready_low", {69'd0, in_ready}, 70'd0);
         end
      join
      check("bp_drained", {69'd0, blk_valid}, 70'd0);

      // Read on the same edge as the 16th byte.
      send_seq(8'h60, 15, 1'b1, 1'b0);
      exp_q.push_back({64'h68696A6B6C6D6E6F, 4'd8, 1'b0, 1'b1});
      blk_read = 1'b1;
      send_beat(8'h6F, 1'b0, 1'b0, 1'b1);
      blk_read = 1'b0;
      idle();
      check("simul_valid", {69'd0, blk_valid}, {69'd0, 1'b1});
      check("simul_ready", {69'd0, in_ready}, {69'd0, 1'b1});
      pulse_read();

      // Reset mid-block discards the partial block.
      send_seq(8'h90, 5, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      @(negedge clk);
      check("rst_outputs", {blk_data, blk_len, blk_last, blk_ad}, 70'd0);
      check("rst_valid_ready", {68'd0, blk_valid, in_ready}, {68'd0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_seq(8'h11, 8, 1'b0, 1'b0);
      idle();
      check("post_rst_fields", {blk_data, blk_len, blk_last, blk_ad},
            {64'h1112131415161718, 4'd8, 1'b0, 1'b0});
      pulse_read();

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 70'(exp_q.size()), 70'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
